// File: rtl/cnn_layer_accel_fetch_pkg.sv
// Shared state encoding, default sizing and statistics record for the row fetch controller.
// Sizing follows the PIXEL_WIDTH / MAX_NUM_INPUT_COLS / MAX_NUM_INPUT_ROWS macros when supplied.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 16
`endif
`ifndef MAX_NUM_INPUT_COLS
`define MAX_NUM_INPUT_COLS 512
`endif
`ifndef MAX_NUM_INPUT_ROWS
`define MAX_NUM_INPUT_ROWS 512
`endif

package cnn_layer_accel_fetch_pkg;

  localparam int PIX_W    = `PIXEL_WIDTH;
  localparam int MAX_COLS = `MAX_NUM_INPUT_COLS;
  localparam int MAX_ROWS = `MAX_NUM_INPUT_ROWS;
  localparam int CW       = $clog2(MAX_COLS);
  localparam int RW       = $clog2(MAX_ROWS);
  localparam int STALL_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    REQ,
    STREAM,
    WAIT,
    DONE
  } fetch_state_t;

  typedef struct packed {
    logic [RW-1:0]      skip_rows;
    logic [RW-1:0]      fetch_rows;
    logic [STALL_W-1:0] stall_cycles;
  } fetch_stats_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [STALL_W-1:0] sat_inc(input logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cnn_layer_accel_row_fetch_stream.sv
// STREAM-phase beat acceptor: counts columns, flags the last beat of the row and
// registers each accepted pixel onto the prefetch buffer write port.
module cnn_layer_accel_row_fetch_stream
  import cnn_layer_accel_fetch_pkg::*;
#(
  parameter int PIXEL_WIDTH = PIX_W,
  parameter int COL_W       = CW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   flush,
  input  logic [COL_W-1:0]       num_cols,
  input  logic                   pix_valid,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   pix_ready,
  output logic                   last_beat,
  output logic                   wr_en,
  output logic [PIXEL_WIDTH-1:0] din
);

  logic [COL_W-1:0] col_cnt;
  logic             accept;

  assign pix_ready = en && (col_cnt < num_cols);
  assign accept    = pix_ready && pix_valid;
  assign last_beat = accept && (col_cnt == num_cols - 1'b1);

  // Accepted beat appears on the write port one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt <= '0;
      wr_en   <= 1'b0;
      din     <= '0;
    end else begin
      wr_en <= accept && !flush;
      if (flush || clear) begin
        col_cnt <= '0;
      end else if (accept) begin
        col_cnt <= col_cnt + 1'b1;
      end
      if (accept) begin
        din <= pix_data;
      end
    end
  end

endmodule

// File: rtl/cnn_layer_accel_row_fetch_ctrl.sv
// Row fetch controller feeding the row prefetch buffer; cancelled rows are retired without a fetch.
// Defining CNN_LAYER_ACCEL_ROW_FETCH_STATS_EN adds skip/fetch/stall statistics outputs.
module cnn_layer_accel_row_fetch_ctrl
  import cnn_layer_accel_fetch_pkg::*;
#(
  parameter  int PIXEL_WIDTH        = PIX_W,
  parameter  int MAX_NUM_INPUT_COLS = MAX_COLS,
  parameter  int MAX_NUM_INPUT_ROWS = MAX_ROWS,
  localparam int COL_W              = $clog2(MAX_NUM_INPUT_COLS),
  localparam int ROW_W              = $clog2(MAX_NUM_INPUT_ROWS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COL_W-1:0]       num_cols,
  input  logic [ROW_W-1:0]       num_rows,
  output logic                   fetch_req_valid,
  input  logic                   fetch_req_ready,
  output logic [ROW_W-1:0]       fetch_req_row,
  input  logic                   pix_valid,
  output logic                   pix_ready,
  input  logic [PIXEL_WIDTH-1:0] pix_data,
  output logic                   wr_en,
  output logic [PIXEL_WIDTH-1:0] din,
  output logic [ROW_W-1:0]       input_row,
  input  logic                   cncl_fetch_req,
  input  logic                   next_row,
  output logic                   job_fetch_ack,
  output logic                   job_complete_ack,
  output logic                   busy
`ifdef CNN_LAYER_ACCEL_ROW_FETCH_STATS_EN
  ,
  output logic [ROW_W-1:0]       stat_skip_rows,
  output logic [ROW_W-1:0]       stat_fetch_rows,
  output logic [STALL_W-1:0]     stat_stall_cycles
`endif
);

  fetch_state_t     state, state_nxt;
  logic [COL_W-1:0] cols_q;
  logic [ROW_W-1:0] rows_q;
  logic [ROW_W-1:0] cur_row;
  logic             nxt_pend;
  logic             last_beat;
  logic             stream_en;
  logic             retire;
  logic             last_row;
  logic             job_empty;

  assign stream_en     = (state == STREAM) && !abort;
  assign retire        = next_row || nxt_pend;
  assign last_row      = (cur_row == rows_q - 1'b1);
  assign job_empty     = (num_cols == '0) || (num_rows == '0);
  assign busy          = (state != IDLE);
  assign input_row     = cur_row;
  assign fetch_req_row = cur_row;

  // Abort takes priority over everything, including acks and the request handshake.
  always_comb begin
    state_nxt        = state;
    fetch_req_valid  = 1'b0;
    job_fetch_ack    = 1'b0;
    job_complete_ack = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) state_nxt = job_empty ? DONE : ACK;
        end
        ACK: begin
          job_fetch_ack = 1'b1;
          state_nxt     = REQ;
        end
        REQ: begin
          if (cncl_fetch_req) begin
            state_nxt = WAIT;
          end else begin
            fetch_req_valid = 1'b1;
            if (fetch_req_ready) state_nxt = STREAM;
          end
        end
        STREAM: begin
          if (last_beat) state_nxt = WAIT;
        end
        WAIT: begin
          if (retire) state_nxt = last_row ? DONE : ACK;
        end
        DONE: begin
          job_complete_ack = 1'b1;
          state_nxt        = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cols_q   <= '0;
      rows_q   <= '0;
      cur_row  <= '0;
      nxt_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        cur_row  <= '0;
        nxt_pend <= 1'b0;
      end else begin
        if (state == IDLE && start) begin
          cols_q  <= num_cols;
          rows_q  <= num_rows;
          cur_row <= '0;
        end
        if (state == WAIT && retire && !last_row) begin
          cur_row <= cur_row + 1'b1;
        end
        // An early next_row is remembered until WAIT retires the row.
        if (state == IDLE || (state == WAIT && retire)) begin
          nxt_pend <= 1'b0;
        end else if (next_row) begin
          nxt_pend <= 1'b1;
        end
      end
    end
  end

  cnn_layer_accel_row_fetch_stream #(
    .PIXEL_WIDTH(PIXEL_WIDTH),
    .COL_W      (COL_W)
  ) u_stream (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (stream_en),
    .clear    (state == ACK),
    .flush    (abort),
    .num_cols (cols_q),
    .pix_valid(pix_valid),
    .pix_data (pix_data),
    .pix_ready(pix_ready),
    .last_beat(last_beat),
    .wr_en    (wr_en),
    .din      (din)
  );

`ifdef CNN_LAYER_ACCEL_ROW_FETCH_STATS_EN
  fetch_stats_t stats_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stats_q <= '0;
    end else if (state == IDLE && start && !abort) begin
      stats_q <= '0;
    end else begin
      if (state == REQ && !abort && cncl_fetch_req) begin
        stats_q.skip_rows <= stats_q.skip_rows + 1'b1;
      end
      if (fetch_req_valid && fetch_req_ready) begin
        stats_q.fetch_rows <= stats_q.fetch_rows + 1'b1;
      end
      if (pix_ready && !pix_valid) begin
        stats_q.stall_cycles <= sat_inc(stats_q.stall_cycles);
      end
    end
  end

  assign stat_skip_rows    = stats_q.skip_rows;
  assign stat_fetch_rows   = stats_q.fetch_rows;
  assign stat_stall_cycles = stats_q.stall_cycles;
`endif

endmodule

// File: tb/tb_cnn_layer_accel_row_fetch_ctrl.sv
// Bench for the row fetch controller: memory engine, consumer and cancel source are
// modelled here; per-job expectations come from the row/column counts and cancel mask.
module tb_cnn_layer_accel_row_fetch_ctrl;

  localparam int PW  = 16;
  localparam int CWB = 9;
  localparam int RWB = 9;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [CWB-1:0] num_cols = '0;
  logic [RWB-1:0] num_rows = '0;
  logic           fetch_req_valid;
  logic           fetch_req_ready = 1'b0;
  logic [RWB-1:0] fetch_req_row;
  logic           pix_valid = 1'b0;
  logic           pix_ready;
  logic [PW-1:0]  pix_data = '0;
  logic           wr_en;
  logic [PW-1:0]  din;
  logic [RWB-1:0] input_row;
  logic           cncl_fetch_req;
  logic           next_row = 1'b0;
  logic           job_fetch_ack;
  logic           job_complete_ack;
  logic           busy;
  logic [511:0]   cancel_mask = '0;
`ifdef CNN_LAYER_ACCEL_ROW_FETCH_STATS_EN
  logic [RWB-1:0] stat_skip_rows;
  logic [RWB-1:0] stat_fetch_rows;
  logic [31:0]    stat_stall_cycles;
`endif

  assign cncl_fetch_req = cancel_mask[input_row];

  always #5 clk = ~clk;

  cnn_layer_accel_row_fetch_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .abort           (abort),
    .num_cols        (num_cols),
    .num_rows        (num_rows),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_req_row   (fetch_req_row),
    .pix_valid       (pix_valid),
    .pix_ready       (pix_ready),
    .pix_data        (pix_data),
    .wr_en           (wr_en),
    .din             (din),
    .input_row       (input_row),
    .cncl_fetch_req  (cncl_fetch_req),
    .next_row        (next_row),
    .job_fetch_ack   (job_fetch_ack),
    .job_complete_ack(job_complete_ack),
    .busy            (busy)
`ifdef CNN_LAYER_ACCEL_ROW_FETCH_STATS_EN
    ,
    .stat_skip_rows   (stat_skip_rows),
    .stat_fetch_rows  (stat_fetch_rows),
    .stat_stall_cycles(stat_stall_cycles)
`endif
  );

  // Mode knobs written only by the main sequence.
  int ready_mode = 0;   // 0: always ready, 1: random
  int valid_mode = 0;   // 0: always valid, 1: random, 2: toggle 1,0,1,0
  int next_mode  = 1;   // 1: consumer pulses next_row a random delay after each fetch ack, 2: at nr_req_cyc
  int nr_req_cyc = -1;
  int job_cols   = 0;

  // Observations written only by the environment process.
  int cyc = 0, n_fack = 0, n_cack = 0, n_wr = 0, lat_err = 0, proto_err = 0;
  int cack_cyc = 0, owed = 0, nr_cnt = -1;
  int req_rows[$];
  int fack_cyc[$];
  logic          prev_acc = 1'b0, prev_stall = 1'b0, tog = 1'b0;
  logic [PW-1:0] prev_data = '0;
  logic [RWB-1:0] prev_row = '0;

  int vectors = 0, miscompares = 0, start_cyc = 0;

  // Environment: observe each cycle just before its active edge, then drive the next cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (wr_en !== prev_acc || (prev_acc && din !== prev_data)) lat_err++;
      if (wr_en === 1'b1) n_wr++;
      if (prev_stall && !abort && (fetch_req_valid !== 1'b1 || fetch_req_row !== prev_row)) proto_err++;
      if (pix_ready === 1'b1 && owed <= 0) proto_err++;
      if (job_fetch_ack === 1'b1) begin
        n_fack++;
        fack_cyc.push_back(cyc);
        if (next_mode == 1) nr_cnt = int'($urandom_range(0, 8));
      end
      if (job_complete_ack === 1'b1) begin
        n_cack++;
        cack_cyc = cyc;
      end
      prev_acc   = pix_valid && pix_ready;
      prev_data  = pix_data;
      if (prev_acc) owed--;
      prev_stall = fetch_req_valid && !fetch_req_ready;
      prev_row   = fetch_req_row;
      if (fetch_req_valid && fetch_req_ready) begin
        req_rows.push_back(int'(fetch_req_row));
        owed += job_cols;
      end
      if (abort) begin
        owed   = 0;
        nr_cnt = -1;
      end
      @(posedge clk);
      #1;
      fetch_req_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
      pix_data = PW'($urandom);
      if (owed > 0) begin
        tog = ~tog;
        case (valid_mode)
          0:       pix_valid = 1'b1;
          1:       pix_valid = ($urandom_range(0, 1) == 1);
          default: pix_valid = tog;
        endcase
      end else begin
        tog       = 1'b0;
        pix_valid = 1'b0;
      end
      next_row = 1'b0;
      if (nr_cnt == 0) next_row = 1'b1;
      if (nr_cnt >= 0) nr_cnt--;
      if (next_mode == 2 && cyc == nr_req_cyc) next_row = 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input int c, input int r);
    job_cols = c;
    step();
    num_cols  = CWB'(c);
    num_rows  = RWB'(r);
    start_cyc = cyc + 1;
    start     = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, input int budget, input string tag);
    int n = 0;
    while (n_cack == c0 && n < budget) begin
      step();
      n++;
    end
    check({tag, " completes"}, int'(n_cack != c0), 1);
  endtask

  task automatic check_job(input string tag, input int c, input int r,
                           input int f0, input int q0, input int w0, input int c0);
    int exp_rows[$];
    for (int i = 0; i < r; i++) if (!cancel_mask[i]) exp_rows.push_back(i);
    check({tag, " fetch acks"}, n_fack - f0, r);
    check({tag, " complete acks"}, n_cack - c0, 1);
    check({tag, " writes"}, n_wr - w0, c * exp_rows.size());
    check({tag, " requests"}, req_rows.size() - q0, exp_rows.size());
    for (int i = 0; i < exp_rows.size() && q0 + i < req_rows.size(); i++)
      check({tag, " request row"}, req_rows[q0 + i], exp_rows[i]);
    check({tag, " write latency/data"}, lat_err, 0);
    check({tag, " handshake protocol"}, proto_err, 0);
    check({tag, " busy after job"}, int'(busy), 0);
  endtask

  initial begin
    int f0, q0, w0, c0, a, b, c;
    repeat (3) step();
    check("reset busy", int'(busy), 0);
    check("reset fetch_req_valid", int'(fetch_req_valid), 0);
    check("reset pix_ready", int'(pix_ready), 0);
    check("reset wr_en", int'(wr_en), 0);
    check("reset acks", int'({job_fetch_ack, job_complete_ack}), 0);
    check("reset input_row", int'(input_row), 0);
    check("reset din", int'(din), 0);
    rst_n = 1'b1;
    step();

    // Plain two-row job; a second start mid-job must be ignored.
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(4, 2);
    num_rows = 9'd5;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(c0, 300, "A");
    check_job("A", 4, 2, f0, q0, w0, c0);

    // Padding row 0 is cancelled; random ready and valid.
    cancel_mask[0] = 1'b1;
    ready_mode = 1; valid_mode = 1;
    c = int'($urandom_range(2, 6));
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(c, 3);
    wait_done(c0, 2000, "B");
    check_job("B", c, 3, f0, q0, w0, c0);
    cancel_mask = '0;

    // Toggling pixel valid.
    ready_mode = 0; valid_mode = 2;
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(3, 1);
    wait_done(c0, 300, "C");
    check_job("C", 3, 1, f0, q0, w0, c0);

    // next_row arrives mid-stream: the row retires the cycle it reaches WAIT.
    valid_mode = 0; next_mode = 2; nr_req_cyc = -1;
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(8, 2);
    for (int n = 0; n < 50 && n_fack == f0; n++) step();
    a = (fack_cyc.size() > f0) ? fack_cyc[f0] : -1000;
    check("D first ack latency", a - start_cyc, 1);
    nr_req_cyc = a + 3;
    for (int n = 0; n < 100 && n_fack < f0 + 2; n++) step();
    b = (fack_cyc.size() > f0 + 1) ? fack_cyc[f0 + 1] : -1000;
    check("D row1 ack spacing", b - a, 8 + 3);
    nr_req_cyc = b + 2;
    wait_done(c0, 300, "D");
    check("D complete spacing", cack_cyc - b, 8 + 3);
    check_job("D", 8, 2, f0, q0, w0, c0);
    next_mode = 1;

    // Abort after two of five beats, then a clean restart.
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(5, 2);
    for (int n = 0; n < 50 && n_fack == f0; n++) step();
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("E busy after abort", int'(busy), 0);
    check("E wr_en after abort", int'(wr_en), 0);
    repeat (10) step();
    check("E writes before abort", n_wr - w0, 2);
    check("E no complete ack", n_cack - c0, 0);
    check("E fetch acks", n_fack - f0, 1);
    check("E protocol", proto_err, 0);
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(3, 2);
    wait_done(c0, 300, "E restart");
    check_job("E restart", 3, 2, f0, q0, w0, c0);

    // Zero-row job goes straight to completion.
    f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
    run_job(4, 0);
    wait_done(c0, 50, "F");
    check("F complete ack latency", cack_cyc - start_cyc, 1);
    check_job("F", 4, 0, f0, q0, w0, c0);

    // Abort and start together: abort wins.
    f0 = n_fack;
    step();
    num_cols = 9'd2; num_rows = 9'd2;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("G busy after abort+start", int'(busy), 0);
    repeat (3) step();
    check("G no fetch ack", n_fack - f0, 0);

    // Randomised jobs against the row/column model.
    for (int j = 0; j < 6; j++) begin
      int cc, rr;
      cc = int'($urandom_range(1, 6));
      rr = int'($urandom_range(1, 5));
      cancel_mask = '0;
      cancel_mask[4:0] = 5'($urandom);
      ready_mode = int'($urandom_range(0, 1));
      valid_mode = int'($urandom_range(0, 1));
      f0 = n_fack; q0 = req_rows.size(); w0 = n_wr; c0 = n_cack;
      run_job(cc, rr);
      wait_done(c0, 3000, "R");
      check_job("R", cc, rr, f0, q0, w0, c0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
